// File: rtl/cook_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cook_timer_ctrl_pkg
//  Purpose  : Shared state codes, BCD limits and the digit clamp helper for
//             the microwave cook-time sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package cook_timer_ctrl_pkg;

    // Sequencer state codes; the raw code is also exported for display/debug
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOADED = 3'd1,
        ST_COOK   = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX  = 4'd5;

    // Saturate a keypad digit to an upper limit
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cook_timer_ctrl_bcd_mmss_dec.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_mmss_dec
//  Purpose  : Combinational one-second decrement of a BCD MM:SS value with
//             borrow (ss 00 -> 59 borrows a minute, ones 0 -> 9 borrows from
//             tens), plus a zero flag for the undecremented input.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_mmss_dec
    import cook_timer_ctrl_pkg::*;
(
    input  logic [15:0] i_mmss,
    output logic [15:0] o_dec,
    output logic        o_zero
);

    logic w_b0;  // seconds ones borrows from seconds tens
    logic w_b1;  // seconds borrow a minute
    logic w_b2;  // minutes ones borrows from minutes tens

    assign w_b0 = (i_mmss[3:0]  == 4'd0);
    assign w_b1 = w_b0 && (i_mmss[7:4]  == 4'd0);
    assign w_b2 = w_b1 && (i_mmss[11:8] == 4'd0);

    assign o_dec[3:0]   = w_b0 ? BCD_MAX_DIGIT : (i_mmss[3:0] - 4'd1);
    assign o_dec[7:4]   = !w_b0 ? i_mmss[7:4]
                        : ((i_mmss[7:4] == 4'd0) ? SEC_TENS_MAX : (i_mmss[7:4] - 4'd1));
    assign o_dec[11:8]  = !w_b1 ? i_mmss[11:8]
                        : ((i_mmss[11:8] == 4'd0) ? BCD_MAX_DIGIT : (i_mmss[11:8] - 4'd1));
    assign o_dec[15:12] = !w_b2 ? i_mmss[15:12]
                        : ((i_mmss[15:12] == 4'd0) ? BCD_MAX_DIGIT : (i_mmss[15:12] - 4'd1));

    assign o_zero = (i_mmss == 16'h0000);

endmodule
`default_nettype wire

// File: rtl/cook_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cook_timer_ctrl
//  Purpose  : Microwave cook-time sequencer. Latches a clamped MM:SS time,
//             counts it down once per 1 Hz tick, drives the magnetron enable,
//             handles pause/resume on door-open or stop, and completion.
//  Config   : `DONE_BEEP_EN adds a completion beeper that stays high for
//             BEEP_TICKS ticks after DONE entry; undefined ties beep to 0.
//  Revision : 1.0  initial release
// ============================================================================
module cook_timer_ctrl
    import cook_timer_ctrl_pkg::*;
#(
    parameter int BEEP_TICKS = 3,
    parameter int MAX_MIN    = 99
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        tick,
    input  logic        load,
    input  logic [3:0]  min_tens,
    input  logic [3:0]  min_ones,
    input  logic [3:0]  sec_tens,
    input  logic [3:0]  sec_ones,
    input  logic        start,
    input  logic        stop,
    input  logic        door_open,
    output logic [15:0] disp,
    output logic        mag_on,
    output logic        done,
    output logic [2:0]  state,
    output logic        beep
);

    localparam logic [3:0] c_max_tens = 4'(MAX_MIN / 10);
    localparam logic [3:0] c_max_ones = 4'(MAX_MIN % 10);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_disp;
    logic [15:0] w_next_disp;
    logic        r_mag_on;
    logic        r_done;

    logic [3:0]  w_mt, w_mo, w_st, w_so;
    logic [7:0]  w_min_bin;
    logic [15:0] w_load_val;
    logic [15:0] w_dec;
    logic        w_zero;

    // Keypad clamp: per-digit saturation, then the minute ceiling
    assign w_mt      = clamp_digit(min_tens, BCD_MAX_DIGIT);
    assign w_mo      = clamp_digit(min_ones, BCD_MAX_DIGIT);
    assign w_st      = clamp_digit(sec_tens, SEC_TENS_MAX);
    assign w_so      = clamp_digit(sec_ones, BCD_MAX_DIGIT);
    assign w_min_bin = ({4'd0, w_mt} * 8'd10) + {4'd0, w_mo};
    assign w_load_val = (w_min_bin > 8'(MAX_MIN)) ? {c_max_tens, c_max_ones, w_st, w_so}
                                                  : {w_mt, w_mo, w_st, w_so};

    bcd_mmss_dec u_dec (
        .i_mmss (r_disp),
        .o_dec  (w_dec),
        .o_zero (w_zero)
    );

    // Next state and next displayed time; branch order encodes input priority
    always_comb begin
        w_next_state = r_state;
        w_next_disp  = r_disp;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_next_state = ST_LOADED;
                    w_next_disp  = w_load_val;
                end
            end
            ST_LOADED: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                    w_next_disp  = 16'h0000;
                end else if (start) begin
                    // A start that cannot cook (door open or no time) still masks load
                    if (!door_open && !w_zero) begin
                        w_next_state = ST_COOK;
                    end
                end else if (load) begin
                    w_next_disp = w_load_val;
                end
            end
            ST_COOK: begin
                if (door_open || stop) begin
                    w_next_state = ST_PAUSE;
                end else if (tick) begin
                    w_next_disp = w_dec;
                    if (r_disp == 16'h0001) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                    w_next_disp  = 16'h0000;
                end else if (start && !door_open) begin
                    w_next_state = ST_COOK;
                end
            end
            ST_DONE: begin
                w_next_disp = 16'h0000;
                if (stop || start) begin
                    w_next_state = ST_IDLE;
                end else if (load) begin
                    w_next_state = ST_LOADED;
                    w_next_disp  = w_load_val;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_disp  = 16'h0000;
            end
        endcase
    end

    // State, time and decoded outputs all register the next state together
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state  <= ST_IDLE;
            r_disp   <= 16'h0000;
            r_mag_on <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_disp   <= w_next_disp;
            r_mag_on <= (w_next_state == ST_COOK);
            r_done   <= (w_next_state == ST_DONE);
        end
    end

    assign disp   = r_disp;
    assign mag_on = r_mag_on;
    assign done   = r_done;
    assign state  = r_state;

`ifdef DONE_BEEP_EN
    localparam logic [1:0] c_beep_last = 2'(BEEP_TICKS - 1);

    logic       r_beep;
    logic [1:0] r_beep_cnt;

    // Beeper: set on DONE entry, count ticks while in DONE, drop on exit
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_beep     <= 1'b0;
            r_beep_cnt <= 2'd0;
        end else if ((w_next_state == ST_DONE) && (r_state != ST_DONE)) begin
            r_beep     <= 1'b1;
            r_beep_cnt <= 2'd0;
        end else if (w_next_state == ST_DONE) begin
            if (r_beep && tick) begin
                r_beep_cnt <= r_beep_cnt + 2'd1;
                if (r_beep_cnt == c_beep_last) begin
                    r_beep <= 1'b0;
                end
            end
        end else begin
            r_beep     <= 1'b0;
            r_beep_cnt <= 2'd0;
        end
    end

    assign beep = r_beep;
`else
    logic w_unused_beep_cfg;

    assign w_unused_beep_cfg = |32'(BEEP_TICKS);
    assign beep = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cook_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cook_timer_ctrl
//  Purpose  : Self-checking bench for cook_timer_ctrl: a vector table, hand
//             sequences for multi-cycle corners, and randomized traffic
//             compared against a seconds-based behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cook_timer_ctrl;

    localparam int BEEP_TICKS = 3;
    localparam int MAX_MIN    = 99;

    logic        clock;
    logic        clear;
    logic        tick;
    logic        load;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic        start;
    logic        stop;
    logic        door_open;
    logic [15:0] disp;
    logic        mag_on;
    logic        done;
    logic [2:0]  state;
    logic        beep;

    int checks   = 0;
    int failures = 0;

    cook_timer_ctrl #(
        .BEEP_TICKS (BEEP_TICKS),
        .MAX_MIN    (MAX_MIN)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .tick      (tick),
        .load      (load),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .start     (start),
        .stop      (stop),
        .door_open (door_open),
        .disp      (disp),
        .mag_on    (mag_on),
        .done      (done),
        .state     (state),
        .beep      (beep)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Behavioural model: remaining time kept as plain seconds
    // ------------------------------------------------------------------
    int m_state = 0;   // 0 idle, 1 loaded, 2 cook, 3 pause, 4 done
    int m_secs  = 0;
    bit m_beep  = 1'b0;
    int m_bticks = 0;

    function automatic int clamp_secs(input logic [15:0] d);
        int mt, mo, st, so, mins;
        mt = int'(d[15:12]); mo = int'(d[11:8]);
        st = int'(d[7:4]);   so = int'(d[3:0]);
        if (mt > 9) mt = 9;
        if (mo > 9) mo = 9;
        if (st > 5) st = 5;
        if (so > 9) so = 9;
        mins = mt * 10 + mo;
        if (mins > MAX_MIN) mins = MAX_MIN;
        return mins * 60 + st * 10 + so;
    endfunction

    function automatic logic [15:0] to_bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    always @(posedge clock) begin
        int ns, nsec;
        logic [15:0] dig;
        dig  = {min_tens, min_ones, sec_tens, sec_ones};
        ns   = m_state;
        nsec = m_secs;
        if (!clear) begin
            ns = 0; nsec = 0;
        end else begin
            case (m_state)
                0: if (load) begin ns = 1; nsec = clamp_secs(dig); end
                1: if (stop) begin ns = 0; nsec = 0; end
                   else if (start) begin if (!door_open && m_secs != 0) ns = 2; end
                   else if (load) nsec = clamp_secs(dig);
                2: if (door_open || stop) ns = 3;
                   else if (tick) begin nsec = m_secs - 1; if (nsec == 0) ns = 4; end
                3: if (stop) begin ns = 0; nsec = 0; end
                   else if (start && !door_open) ns = 2;
                4: if (stop || start) begin ns = 0; nsec = 0; end
                   else if (load) begin ns = 1; nsec = clamp_secs(dig); end
                default: begin ns = 0; nsec = 0; end
            endcase
        end
`ifdef DONE_BEEP_EN
        if (!clear) begin
            m_beep = 1'b0; m_bticks = 0;
        end else if (ns == 4 && m_state != 4) begin
            m_beep = 1'b1; m_bticks = 0;
        end else if (ns == 4 && m_beep && tick) begin
            m_bticks = m_bticks + 1;
            if (m_bticks >= BEEP_TICKS) m_beep = 1'b0;
        end else if (ns != 4) begin
            m_beep = 1'b0;
        end
`else
        m_beep = 1'b0;
`endif
        m_state = ns;
        m_secs  = nsec;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic c, input logic t, input logic l, input logic [15:0] d,
                          input logic s, input logic p, input logic o);
        clear = c; tick = t; load = l;
        {min_tens, min_ones, sec_tens, sec_ones} = d;
        start = s; stop = p; door_open = o;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        clr, tck, ld;
        logic [15:0] dig;
        logic        st, sp, dr;
        logic [2:0]  e_state;
        logic [15:0] e_disp;
        logic        e_mag, e_done;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    bit exp_beep;

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        //          clr  tck  ld   digits    st   sp   dr   state disp     mag  done
        vecs[0]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,16'h0000,1'b1,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b1,16'hAF99,1'b0,1'b0,1'b0,3'd1,16'h9959,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b1,16'h0000,1'b0,1'b0,1'b0,3'd1,16'h0000,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,16'h0000,1'b1,1'b0,1'b0,3'd1,16'h0000,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b1,16'h0230,1'b0,1'b0,1'b0,3'd1,16'h0230,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b0,16'h0000,1'b1,1'b0,1'b0,3'd2,16'h0230,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,3'd2,16'h0229,1'b1,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b1,16'h0500,1'b0,1'b0,1'b0,3'd2,16'h0228,1'b1,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,1'b0,16'h0000,1'b1,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b1,16'h0045,1'b0,1'b0,1'b0,3'd1,16'h0045,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b0,1'b0,16'h0000,1'b1,1'b1,1'b0,3'd0,16'h0000,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b1,16'h0012,1'b0,1'b0,1'b0,3'd1,16'h0012,1'b0,1'b0};
        vecs[14] = '{1'b1,1'b0,1'b0,16'h0000,1'b1,1'b0,1'b0,3'd2,16'h0012,1'b1,1'b0};
        vecs[15] = '{1'b1,1'b1,1'b0,16'h0000,1'b0,1'b1,1'b0,3'd3,16'h0012,1'b0,1'b0};
        vecs[16] = '{1'b1,1'b0,1'b0,16'h0000,1'b1,1'b0,1'b1,3'd3,16'h0012,1'b0,1'b0};
        vecs[17] = '{1'b1,1'b0,1'b1,16'h0300,1'b0,1'b0,1'b0,3'd3,16'h0012,1'b0,1'b0};
        vecs[18] = '{1'b1,1'b0,1'b0,16'h0000,1'b1,1'b0,1'b0,3'd2,16'h0012,1'b1,1'b0};
        vecs[19] = '{1'b1,1'b0,1'b0,16'h0000,1'b0,1'b1,1'b0,3'd3,16'h0012,1'b0,1'b0};
        vecs[20] = '{1'b1,1'b0,1'b0,16'h0000,1'b0,1'b1,1'b0,3'd0,16'h0000,1'b0,1'b0};
        vecs[21] = '{1'b1,1'b0,1'b1,16'h1799,1'b0,1'b0,1'b0,3'd1,16'h1759,1'b0,1'b0};
        vecs[22] = '{1'b1,1'b0,1'b1,16'h9C63,1'b0,1'b0,1'b0,3'd1,16'h9953,1'b0,1'b0};

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].clr, vecs[i].tck, vecs[i].ld, vecs[i].dig,
                   vecs[i].st, vecs[i].sp, vecs[i].dr);
            cyc();
            chk($sformatf("vec%0d_state", i), 32'(state),  32'(vecs[i].e_state));
            chk($sformatf("vec%0d_disp", i),  32'(disp),   32'(vecs[i].e_disp));
            chk($sformatf("vec%0d_mag", i),   32'(mag_on), 32'(vecs[i].e_mag));
            chk($sformatf("vec%0d_done", i),  32'(done),   32'(vecs[i].e_done));
            chk($sformatf("vec%0d_beep", i),  32'(beep),   32'd0);
        end

        // Full countdown from 01:05 through the minute borrow to DONE
        set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b1, 1'b0, 1'b1, 16'h0105, 1'b0, 1'b0, 1'b0); cyc();
        chk("cd_loaded", 32'(disp), 32'h0105);
        set_in(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cyc();
        chk("cd_cook_mag", 32'(mag_on), 32'd1);
        for (int k = 1; k <= 65; k++) begin
            set_in(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
            chk($sformatf("cd_disp_t%0d", k), 32'(disp), 32'(to_bcd(65 - k)));
            if (k < 65) begin
                chk($sformatf("cd_state_t%0d", k), 32'(state), 32'd2);
                set_in(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
            end
        end
        chk("cd_done_state", 32'(state), 32'd4);
        chk("cd_done_flag", 32'(done), 32'd1);
        chk("cd_done_mag", 32'(mag_on), 32'd0);
`ifdef DONE_BEEP_EN
        exp_beep = 1'b1;
`else
        exp_beep = 1'b0;
`endif
        chk("beep_entry", 32'(beep), 32'(exp_beep));

        // Beeper holds for BEEP_TICKS ticks after completion
        for (int k = 1; k <= BEEP_TICKS + 1; k++) begin
            set_in(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
`ifdef DONE_BEEP_EN
            exp_beep = (k < BEEP_TICKS);
`else
            exp_beep = 1'b0;
`endif
            chk($sformatf("beep_t%0d", k), 32'(beep), 32'(exp_beep));
            chk($sformatf("beep_state_t%0d", k), 32'(state), 32'd4);
        end
        set_in(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cyc();
        chk("done_start_idle", 32'(state), 32'd0);

        // Leaving DONE early drops the beeper
        set_in(1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cyc();
        set_in(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
        chk("early_done", 32'(state), 32'd4);
        set_in(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); cyc();
        chk("early_idle", 32'(state), 32'd0);
        chk("early_beep", 32'(beep), 32'd0);

        // Door-open pause at 00:07, then resume
        set_in(1'b1, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cyc();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
            set_in(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
        end
        chk("door_pre", 32'(disp), 32'h0007);
        set_in(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cyc();
        chk("door_state", 32'(state), 32'd3);
        chk("door_disp", 32'(disp), 32'h0007);
        chk("door_mag", 32'(mag_on), 32'd0);
        set_in(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cyc();
        chk("resume_state", 32'(state), 32'd2);
        chk("resume_mag", 32'(mag_on), 32'd1);
        set_in(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
        chk("resume_disp", 32'(disp), 32'h0006);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 299) != 0),
                   ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 7) == 0),
                   {(($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd0),
                    4'($urandom_range(0, 1)), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 15))},
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 15) == 0),
                   ($urandom_range(0, 9) == 0));
            cyc();
            chk("rand_state", 32'(state),  32'(m_state));
            chk("rand_disp",  32'(disp),   32'(to_bcd(m_secs)));
            chk("rand_mag",   32'(mag_on), 32'(m_state == 2));
            chk("rand_done",  32'(done),   32'(m_state == 4));
            chk("rand_beep",  32'(beep),   32'(m_beep));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
